// File: rtl/fetch_issue_ctrl.sv
// rtl/fetch_issue_ctrl.sv - round-robin fetch issue controller, one outstanding instruction fetch
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_issue_ctrl #(
  parameter int NUM_WF  = 40,
  parameter int WF_ID_W = 6,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  wf_ready,
  output logic               pc_rd_en,
  output logic [WF_ID_W-1:0] pc_wf_id_rd,
  input  logic [PC_W:0]      pc_data,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic               mem_rdata_valid,
  input  logic [PC_W-1:0]    mem_rdata,
  input  logic               flush_valid,
  input  logic [WF_ID_W-1:0] flush_wf_id,
  output logic               ibuf_wr,
  output logic [WF_ID_W-1:0] ibuf_wf_id,
  output logic [PC_W-1:0]    ibuf_instr,
  output logic               ibuf_first,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t               state, state_nxt;
  logic [WF_ID_W-1:0]   rr_ptr;
  logic [WF_ID_W-1:0]   tag;
  logic                 first;
  logic                 drop;
  logic                 flush_hit;
  logic [2*NUM_WF-1:0]  rot_dbl;
  logic [NUM_WF-1:0]    rot;
  logic                 found;
  logic [WF_ID_W-1:0]   win_off;
  logic [WF_ID_W:0]     win_sum;
  logic [WF_ID_W-1:0]   winner;

  // Rotate the ready vector so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot_dbl = {wf_ready, wf_ready} >> rr_ptr;
    rot     = rot_dbl[NUM_WF-1:0];
    found   = |rot;
    win_off = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (rot[i]) win_off = WF_ID_W'(i);
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= (WF_ID_W+1)'(NUM_WF)) win_sum = win_sum - (WF_ID_W+1)'(NUM_WF);
    winner = win_sum[WF_ID_W-1:0];
  end

  assign flush_hit = flush_valid && (flush_wf_id == tag) && ((state == REQ) || (state == WAIT));

  always_comb begin
    state_nxt   = state;
    pc_rd_en    = 1'b0;
    pc_wf_id_rd = '0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          pc_rd_en    = 1'b1;
          pc_wf_id_rd = winner;
          state_nxt   = REQ;
        end
      end
      REQ:     if (mem_ack) state_nxt = WAIT;
      WAIT:    if (mem_rdata_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      tag        <= '0;
      first      <= 1'b0;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ibuf_wr    <= 1'b0;
      ibuf_wf_id <= '0;
      ibuf_instr <= '0;
      ibuf_first <= 1'b0;
    end else begin
      ibuf_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_rd_en) begin
            mem_addr <= pc_data[PC_W-1:0];
            first    <= pc_data[PC_W];
            tag      <= winner;
            rr_ptr   <= (winner == WF_ID_W'(NUM_WF - 1)) ? '0 : winner + 1'b1;
            mem_req  <= 1'b1;
          end
        end
        REQ: begin
          if (flush_hit) drop <= 1'b1;
          if (mem_ack) mem_req <= 1'b0;
        end
        WAIT: begin
          if (flush_hit) drop <= 1'b1;
          // A flush landing on the response cycle still discards the instruction.
          if (mem_rdata_valid) begin
            drop <= 1'b0;
            if (!(drop || flush_hit)) begin
              ibuf_wr    <= 1'b1;
              ibuf_wf_id <= tag;
              ibuf_instr <= mem_rdata;
              ibuf_first <= first;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (ibuf_wr) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == REQ) && !mem_ack) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
